mdu: RTL and testbench

- Multi-cycle multiply/divide unit for the CPU7 execute stage, alongside the single-cycle ALU.
- Executes MULT/MULTU/DIV/DIVU with fixed latency and owns the HI/LO registers.
- Serves MFHI/MFLO/MTHI/MTLO.
- Exports start/busy so hazard logic stalls any MDU instruction in D while an operation is in flight.

---
 rtl/mdu_pkg.sv | 35 +++
 rtl/mdu.sv | 161 ++++++++++++++++
 tb/tb_mdu.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// Shared MDU definitions: operation encodings used by control decode and the MDU,
// default latencies and the FSM state type.
package mdu_pkg;

   typedef enum logic [3:0] {
      MDU_NONE  = 4'd0,
      MDU_MULT  = 4'd1,
      MDU_MULTU = 4'd2,
      MDU_DIV   = 4'd3,
      MDU_DIVU  = 4'd4,
      MDU_MFHI  = 4'd5,
      MDU_MFLO  = 4'd6,
      MDU_MTHI  = 4'd7,
      MDU_MTLO  = 4'd8
   } mdu_op_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } mdu_state_e;

   localparam int unsigned MDU_MULT_CYCLES = 5;
   localparam int unsigned MDU_DIV_CYCLES  = 10;
   localparam int unsigned MDU_CNT_W       = 8;

   // True for the four operations that occupy the unit for several cycles.
   function automatic logic mdu_is_arith(input logic [3:0] op);
      return (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_DIV) || (op == MDU_DIVU);
   endfunction

   function automatic logic mdu_is_div(input logic [3:0] op);
      return (op == MDU_DIV) || (op == MDU_DIVU);
   endfunction

endpackage

// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit owning HI/LO. The result is computed on the
// start edge and held in a pending buffer until the latency counter expires.
module mdu
   import mdu_pkg::*;
#(
   parameter int unsigned MULT_CYCLES = MDU_MULT_CYCLES,
   parameter int unsigned DIV_CYCLES  = MDU_DIV_CYCLES
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  MDU_op,
   input  logic        start,
   input  logic        req,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic        busy,
   output logic [31:0] HI,
   output logic [31:0] LO,
   output logic [31:0] MDU_result
);

   mdu_state_e           state_q, state_d;
   logic [MDU_CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0]          pend_hi_q, pend_hi_d;
   logic [31:0]          pend_lo_q, pend_lo_d;
   logic                 pend_wr_q, pend_wr_d;
   logic [31:0]          hi_q, hi_d;
   logic [31:0]          lo_q, lo_d;

   logic [63:0] smul_s;
   logic [63:0] umul_s;
   logic [31:0] sdiv_b_s;
   logic [31:0] udiv_b_s;
   logic [31:0] squo_s, srem_s;
   logic [31:0] uquo_s, urem_s;
   logic [63:0] res_s;
   logic        res_wr_s;
   logic        idle_s;
   logic        launch_s;
   logic        mt_s;

   assign idle_s   = (state_q == ST_IDLE);
   assign launch_s = idle_s && start && !req && mdu_is_arith(MDU_op);
   assign mt_s     = idle_s && !start && !req;

   // Divisor substitution keeps the dividers defined: x/0 is discarded later, and
   // INT_MIN/-1 divided by 1 already yields the wrapped quotient with zero remainder.
   assign sdiv_b_s = ((B == 32'd0) || ((A == 32'h8000_0000) && (B == 32'hFFFF_FFFF))) ? 32'd1 : B;
   assign udiv_b_s = (B == 32'd0) ? 32'd1 : B;

   // Behavioural arithmetic for all four operations.
   always_comb begin
      smul_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
      umul_s = {32'd0, A} * {32'd0, B};
      squo_s = $signed(A) / $signed(sdiv_b_s);
      srem_s = $signed(A) % $signed(sdiv_b_s);
      uquo_s = A / udiv_b_s;
      urem_s = A % udiv_b_s;
   end

   // Select the 64-bit {HI,LO} result and whether it may be committed.
   always_comb begin
      res_s    = 64'd0;
      res_wr_s = 1'b1;
      case (MDU_op)
         MDU_MULT:  res_s = smul_s;
         MDU_MULTU: res_s = umul_s;
         MDU_DIV:   res_s = {srem_s, squo_s};
         MDU_DIVU:  res_s = {urem_s, uquo_s};
         default:   res_s = 64'd0;
      endcase
      if (mdu_is_div(MDU_op) && (B == 32'd0)) begin
         res_wr_s = 1'b0;
      end else begin
         res_wr_s = 1'b1;
      end
   end

   // Next-state logic for the IDLE/RUN controller and the HI/LO registers.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      pend_hi_d = pend_hi_q;
      pend_lo_d = pend_lo_q;
      pend_wr_d = pend_wr_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      case (state_q)
         ST_IDLE: begin
            if (launch_s) begin
               state_d   = ST_RUN;
               cnt_d     = mdu_is_div(MDU_op) ? MDU_CNT_W'(DIV_CYCLES) : MDU_CNT_W'(MULT_CYCLES);
               pend_hi_d = res_s[63:32];
               pend_lo_d = res_s[31:0];
               pend_wr_d = res_wr_s;
            end else if (mt_s && (MDU_op == MDU_MTHI)) begin
               hi_d = A;
            end else if (mt_s && (MDU_op == MDU_MTLO)) begin
               lo_d = A;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            // Requests and new starts are ignored here; the operation always completes.
            if (cnt_q == MDU_CNT_W'(1)) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
               if (pend_wr_q) begin
                  hi_d = pend_hi_q;
                  lo_d = pend_lo_q;
               end else begin
                  hi_d = hi_q;
                  lo_d = lo_q;
               end
            end else begin
               cnt_d = cnt_q - MDU_CNT_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // State, counter, pending result and HI/LO registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         pend_hi_q <= 32'd0;
         pend_lo_q <= 32'd0;
         pend_wr_q <= 1'b0;
         hi_q      <= 32'd0;
         lo_q      <= 32'd0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         pend_hi_q <= pend_hi_d;
         pend_lo_q <= pend_lo_d;
         pend_wr_q <= pend_wr_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
      end
   end

   assign busy = (state_q == ST_RUN);
   assign HI   = hi_q;
   assign LO   = lo_q;

   // MFHI/MFLO read path.
   always_comb begin
      case (MDU_op)
         MDU_MFHI: MDU_result = hi_q;
         MDU_MFLO: MDU_result = lo_q;
         default:  MDU_result = 32'd0;
      endcase
   end

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: directed cases plus randomized operations against
// an arithmetic reference model, with a scoreboard checked when busy falls.
module tb_mdu;
   import mdu_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [3:0]  MDU_op = 4'd0;
   logic        start = 1'b0;
   logic        req = 1'b0;
   logic [31:0] A = 32'd0;
   logic [31:0] B = 32'd0;
   logic        busy;
   logic [31:0] HI, LO, MDU_result;

   int n_tests = 0;
   int n_fail  = 0;

   logic [63:0] exp_q[$];
   logic [31:0] m_hi = 32'd0;
   logic [31:0] m_lo = 32'd0;
   logic [63:0] last_exp;

   mdu dut (
      .clk(clk), .reset(reset), .MDU_op(MDU_op), .start(start), .req(req),
      .A(A), .B(B), .busy(busy), .HI(HI), .LO(LO), .MDU_result(MDU_result)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: {HI,LO} after the operation, from plain 64-bit arithmetic.
   function automatic logic [63:0] ref_res(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input logic [31:0] hi,
                                           input logic [31:0] lo);
      longint          sa, sb, q, r;
      longint unsigned ua, ub, p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'd0, a};
      ub = {32'd0, b};
      case (op)
         4'd1: begin q = sa * sb; return q; end
         4'd2: begin p = ua * ub; return p; end
         4'd3: begin
            if (b == 32'd0) return {hi, lo};
            q = sa / sb;
            r = sa % sb;
            return {r[31:0], q[31:0]};
         end
         4'd4: begin
            if (b == 32'd0) return {hi, lo};
            return {a % b, a / b};
         end
         default: return {hi, lo};
      endcase
   endfunction

   function automatic int lat(input logic [3:0] op);
      return (op == 4'd3 || op == 4'd4) ? 10 : 5;
   endfunction

   // Scoreboard monitor: compares HI/LO against the queued expectation when busy falls.
   initial begin
      logic        prev_busy;
      logic [63:0] e;
      prev_busy = 1'b0;
      forever begin
         @(negedge clk);
         if (!reset) begin
            prev_busy = 1'b0;
         end else begin
            if (prev_busy && !busy) begin
               if (exp_q.size() == 0) begin
                  check("sb_unexpected_done", 32'd1, 32'd0);
               end else begin
                  e = exp_q.pop_front();
                  check("sb_hi", HI, e[63:32]);
                  check("sb_lo", LO, e[31:0]);
               end
            end
            prev_busy = busy;
         end
      end
   end

   task automatic launch(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic r);
      @(negedge clk);
      MDU_op = op; A = a; B = b; start = 1'b1; req = r;
      if (!r && op >= 4'd1 && op <= 4'd4) begin
         last_exp = ref_res(op, a, b, m_hi, m_lo);
         exp_q.push_back(last_exp);
      end
      @(posedge clk);
      #1;
      start = 1'b0; req = 1'b0; MDU_op = 4'd0;
      A = $urandom; B = $urandom;
   endtask

   // Counts busy cycles, checks HI/LO hold while busy, then advances the model.
   task automatic wait_done(input int exp_n);
      int n;
      n = 0;
      forever begin
         @(negedge clk);
         if (busy && n < 60) begin
            n++;
            check("hold_hi", HI, m_hi);
            check("hold_lo", LO, m_lo);
         end else begin
            break;
         end
      end
      check("latency", 32'(n), 32'(exp_n));
      m_hi = last_exp[63:32];
      m_lo = last_exp[31:0];
   endtask

   task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      launch(op, a, b, 1'b0);
      wait_done(lat(op));
   endtask

   task automatic mt(input logic [3:0] op, input logic [31:0] a, input logic r);
      @(negedge clk);
      MDU_op = op; A = a; start = 1'b0; req = r;
      @(posedge clk);
      #1;
      MDU_op = 4'd0; req = 1'b0;
      if (!r && op == 4'd7) m_hi = a;
      if (!r && op == 4'd8) m_lo = a;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0]  op;
      logic [31:0] ra, rb;

      #13;
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_hi", HI, 32'd0);
      check("rst_lo", LO, 32'd0);
      @(negedge clk);
      #2 reset = 1'b1;

      run_op(4'd1, 32'hFFFF_FFFE, 32'd3);
      check("mult_hi", HI, 32'hFFFF_FFFF);
      check("mult_lo", LO, 32'hFFFF_FFFA);
      run_op(4'd2, 32'hFFFF_FFFF, 32'd2);
      check("multu_hi", HI, 32'h0000_0001);
      check("multu_lo", LO, 32'hFFFF_FFFE);
      run_op(4'd3, 32'hFFFF_FFF9, 32'd2);
      check("div_lo", LO, 32'hFFFF_FFFD);
      check("div_hi", HI, 32'hFFFF_FFFF);
      run_op(4'd4, 32'd7, 32'd2);
      check("divu_lo", LO, 32'd3);
      check("divu_hi", HI, 32'd1);

      mt(4'd7, 32'h1234, 1'b0);
      mt(4'd8, 32'h5678, 1'b0);
      run_op(4'd4, 32'd99, 32'd0);
      check("div0_hi", HI, 32'h1234);
      check("div0_lo", LO, 32'h5678);

      run_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
      check("ovf_lo", LO, 32'h8000_0000);
      check("ovf_hi", HI, 32'd0);

      // Suppression by req.
      launch(4'd1, 32'd1000, 32'd1000, 1'b1);
      repeat (3) begin
         @(negedge clk);
         check("req_busy", {31'd0, busy}, 32'd0);
      end
      check("req_hi", HI, m_hi);
      check("req_lo", LO, m_lo);
      mt(4'd8, 32'hDEAD_BEEF, 1'b1);
      @(negedge clk);
      check("req_mtlo", LO, m_lo);

      // Combinational read path.
      mt(4'd7, 32'hCAFE_0001, 1'b0);
      mt(4'd8, 32'hCAFE_0002, 1'b0);
      @(negedge clk);
      MDU_op = 4'd5; #1;
      check("mfhi", MDU_result, m_hi);
      MDU_op = 4'd6; #1;
      check("mflo", MDU_result, m_lo);
      MDU_op = 4'd7; #1;
      check("mf_other", MDU_result, 32'd0);
      MDU_op = 4'd0;

      // Randomized operations interleaved with moves.
      for (int i = 0; i < 30; i++) begin
         ra = $urandom;
         rb = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
         if ($urandom_range(0, 3) == 0) rb = {28'd0, 4'($urandom)};
         if ($urandom_range(0, 4) == 0) begin
            mt($urandom_range(0, 1) ? 4'd7 : 4'd8, ra, 1'($urandom));
         end else begin
            op = 4'($urandom_range(1, 4));
            run_op(op, ra, rb);
         end
      end

      // Asynchronous reset in busy cycle 3 of a DIV.
      mt(4'd7, 32'h0BAD_F00D, 1'b0);
      launch(4'd3, 32'd100, 32'd7, 1'b0);
      repeat (3) @(negedge clk);
      void'(exp_q.pop_back());
      #2 reset = 1'b0;
      #1;
      check("arst_busy", {31'd0, busy}, 32'd0);
      check("arst_hi", HI, 32'd0);
      check("arst_lo", LO, 32'd0);
      m_hi = 32'd0; m_lo = 32'd0;
      @(negedge clk);
      #2 reset = 1'b1;
      repeat (14) @(negedge clk);
      check("post_busy", {31'd0, busy}, 32'd0);
      check("post_hi", HI, 32'd0);
      check("post_lo", LO, 32'd0);
      check("sb_drained", 32'(exp_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
